// File: rtl/pwm_capture.sv
// pwm_capture
//   Receive-side counterpart of the PWM generator. Samples an asynchronous
//   PWM waveform on clk1ms and measures high time and rise-to-rise period in
//   clock cycles. Each completed period is published with a one-cycle valid
//   strobe. A line that stops toggling long enough to saturate the counter
//   raises stuck.
//
//   Optional feature: define PWM_CAP_FILTER_EN to insert a 3-sample glitch
//   filter after the synchronizer. This adds 2 cycles of latency and
//   suppresses pulses shorter than 3 cycles.
//
// Parameters
//   CNT_W         width of the internal counter and the measurement outputs
//
// Ports
//   clk1ms        in   sampling clock (the only clock)
//   reset         in   asynchronous, active-high reset
//   pwm_in        in   asynchronous PWM waveform
//   high_count    out  high time of the last complete period, in cycles
//   period_count  out  rise-to-rise length of the last complete period
//   valid         out  one-cycle strobe when the counts update
//   stuck         out  set on counter saturation, cleared by the next valid
//   state         out  FSM state for debug: IDLE=0 HIGH=1 LOW=2 STUCK=3
module pwm_capture #(
    parameter int CNT_W = 26
) (
    input  logic             clk1ms,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             valid,
    output logic             stuck,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HIGH  = 2'b01,
        LOW   = 2'b10,
        STUCK = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Counts never wrap: the counter parks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    state_t           cur_state;
    state_t           next_state;
    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             level;
    logic             rise;
    logic             fall;
    logic             report;
    logic             take_high;
    logic             timeout;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_latch;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk1ms or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    // The filtered level follows sync2 only once the current and the two
    // previous sync2 samples agree. prev holds the filtered level, so the
    // combinational next level doubles as the edge-detect input.
    logic hist0;
    logic hist1;
    logic agree;

    always_ff @(posedge clk1ms or posedge reset) begin
        if (reset) begin
            hist0 <= 1'b0;
            hist1 <= 1'b0;
        end else begin
            hist0 <= sync2;
            hist1 <= hist0;
        end
    end

    assign agree = (sync2 == hist0) && (hist0 == hist1);
    assign level = agree ? sync2 : prev;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk1ms or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

    always_ff @(posedge clk1ms or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // An edge always wins over the timeout, so a period of exactly
    // 2^CNT_W-1 cycles is still reported.
    always_comb begin
        next_state = cur_state;
        report     = 1'b0;
        take_high  = 1'b0;
        timeout    = 1'b0;
        unique case (cur_state)
            IDLE, STUCK: begin
                if (rise) begin
                    next_state = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    next_state = LOW;
                    take_high  = 1'b1;
                end else if (!rise && cnt == CNT_MAX) begin
                    next_state = STUCK;
                    timeout    = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    next_state = HIGH;
                    report     = 1'b1;
                end else if (!fall && cnt == CNT_MAX) begin
                    next_state = STUCK;
                    timeout    = 1'b1;
                end
            end
        endcase
    end

    // cnt restarts at 1 on each rise, so at the next rise it holds the
    // period and at the fall it holds the high time.
    always_ff @(posedge clk1ms or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            high_latch <= '0;
        end else begin
            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (cur_state == HIGH || cur_state == LOW) begin
                cnt <= sat_inc(cnt);
            end
            if (take_high) begin
                high_latch <= cnt;
            end
        end
    end

    always_ff @(posedge clk1ms or posedge reset) begin
        if (reset) begin
            high_count   <= '0;
            period_count <= '0;
            valid        <= 1'b0;
            stuck        <= 1'b0;
        end else begin
            valid <= report;
            if (report) begin
                period_count <= cnt;
                high_count   <= high_latch;
            end
            if (timeout) begin
                stuck <= 1'b1;
            end else if (report) begin
                stuck <= 1'b0;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Directed and randomized stimulus for pwm_capture (default build, no
//   glitch filter) with CNT_W=4 so that saturation is reachable quickly.
//   The reference model works on waveform edges and their timestamps: the
//   pin level seen by the capture logic is the driven level delayed two
//   cycles, each rise closes a period whose length and high time are plain
//   timestamp differences, and a rise that stays unanswered for 2^CNT_W-1
//   cycles times out.
module tb_pwm_capture;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk1ms = 1'b0;
    logic             reset  = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_count;
    logic [CNT_W-1:0] period_count;
    logic             valid;
    logic             stuck;
    logic [1:0]       state;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk1ms       (clk1ms),
        .reset        (reset),
        .pwm_in       (pwm_in),
        .high_count   (high_count),
        .period_count (period_count),
        .valid        (valid),
        .stuck        (stuck),
        .state        (state)
    );

    always #20 clk1ms = ~clk1ms;

    // Reference model state
    int s;
    bit h0, h1, h2;
    bit tracking, have_fall, timed_out;
    int t_rise, t_fall;
    int exp_hc, exp_pc;
    bit exp_v, exp_stuck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        s = 0;
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
        tracking = 1'b0; have_fall = 1'b0; timed_out = 1'b0;
        t_rise = 0; t_fall = 0;
        exp_hc = 0; exp_pc = 0;
        exp_v = 1'b0; exp_stuck = 1'b0;
    endtask

    task automatic model_step(input bit lvl);
        bit cur, prv;
        cur = h1;
        prv = h2;
        exp_v = 1'b0;
        if (cur && !prv) begin
            if (tracking && have_fall) begin
                exp_v     = 1'b1;
                exp_pc    = s - t_rise;
                exp_hc    = t_fall - t_rise;
                exp_stuck = 1'b0;
            end
            tracking  = 1'b1;
            have_fall = 1'b0;
            t_rise    = s;
        end else if (!cur && prv) begin
            if (tracking && !have_fall) begin
                have_fall = 1'b1;
                t_fall    = s;
            end
        end else if (tracking && (s - t_rise) >= MAXC) begin
            tracking  = 1'b0;
            timed_out = 1'b1;
            exp_stuck = 1'b1;
        end
        h2 = h1;
        h1 = h0;
        h0 = lvl;
        s++;
    endtask

    function automatic int exp_state();
        if (tracking) return have_fall ? 2 : 1;
        return timed_out ? 3 : 0;
    endfunction

    // Drive one cycle of pin level, then compare all outputs on the falling edge.
    task automatic step(input bit lvl);
        pwm_in = lvl;
        @(posedge clk1ms);
        @(negedge clk1ms);
        model_step(lvl);
        check($sformatf("valid@%0d", s), 32'(valid), 32'(exp_v));
        check($sformatf("stuck@%0d", s), 32'(stuck), 32'(exp_stuck));
        check($sformatf("state@%0d", s), 32'(state), 32'(exp_state()));
        check($sformatf("high_count@%0d", s), 32'(high_count), 32'(exp_hc));
        check($sformatf("period_count@%0d", s), 32'(period_count), 32'(exp_pc));
    endtask

    task automatic pulse(input int h, input int l);
        repeat (h) step(1'b1);
        repeat (l) step(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_stuck", 32'(stuck), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_high_count", 32'(high_count), 32'd0);
        check("rst_period_count", 32'(period_count), 32'd0);
        @(posedge clk1ms);
        @(negedge clk1ms);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int p, h;
        model_reset();

        // Reset values
        repeat (2) @(negedge clk1ms);
        do_reset();

        // Steady 10-cycle period, 3 high; first rise gives no valid
        repeat (2) step(1'b0);
        repeat (6) pulse(3, 7);
        check("steady_period", 32'(period_count), 32'd10);
        check("steady_high", 32'(high_count), 32'd3);

        // Duty change at constant 8-cycle period
        repeat (3) pulse(2, 6);
        check("duty_a_high", 32'(high_count), 32'd2);
        check("duty_a_period", 32'(period_count), 32'd8);
        repeat (3) pulse(6, 2);
        check("duty_b_high", 32'(high_count), 32'd6);
        check("duty_b_period", 32'(period_count), 32'd8);

        // One-cycle glitch inside a low phase is measured as its own period
        pulse(3, 3);
        pulse(1, 3);
        pulse(3, 4);
        check("glitch_high", 32'(high_count), 32'd1);
        check("glitch_period", 32'(period_count), 32'd4);
        pulse(3, 4);

        // Reset in the middle of a low phase
        pulse(3, 5);
        check("pre_reset_state", 32'(state), 32'd2);
        do_reset();
        pulse(3, 5);
        pulse(3, 5);
        pulse(3, 5);
        check("post_reset_period", 32'(period_count), 32'd8);

        // Line held high saturates the counter and enters STUCK
        do_reset();
        repeat (20) step(1'b1);
        check("stuck_flag", 32'(stuck), 32'd1);
        check("stuck_state", 32'(state), 32'd3);
        repeat (2) step(1'b0);
        pulse(2, 4);
        pulse(2, 4);
        check("recover_high", 32'(high_count), 32'd2);
        check("recover_period", 32'(period_count), 32'd6);
        check("recover_stuck", 32'(stuck), 32'd0);

        // Randomized periods up to the maximum reportable length
        for (int i = 0; i < 30; i++) begin
            p = int'($urandom_range(15, 2));
            h = int'($urandom_range(p - 1, 1));
            pulse(h, p - h);
        end
        repeat (3) step(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
